uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial receiver that is the downstream counterpart of uart_tx. Line format is 8N1-style: one start bit (0), DATA_WIDTH data bits LSB first, one stop bit (1), idle high. The block synchronises the line, samples each bit at mid-bit, assembles words and buffers them in a receive FIFO for the host. Interop target: connecting uart_tx.tx_bit_o to rx_bit_i must deliver every transmitted word unchanged.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, line rate; BAUD_DIV = CLK_FREQ/BAUD_RATE (434 at defaults, integer truncation)
DATA_WIDTH, 8, data bits per frame
FIFO_DEPTH, 16, receive FIFO entries; must be a power of 2, minimum 2

Ports:
clk_i  in  1  single system clock, rising edge
rst_i  in  1  synchronous, active-high reset
rx_en_i  in  1  receiver enable; gates start-bit detection only
rx_bit_i  in  1  asynchronous serial line input, idle high
rx_ren_i  in  1  FIFO pop strobe, one word per cycle high
dout_o  out  DATA_WIDTH  FIFO head, first-word-fall-through, valid when empty_o=0
empty_o  out  1  FIFO empty
full_o  out  1  FIFO full
frame_err_o  out  1  one-cycle pulse: stop bit sampled 0
overrun_o  out  1  one-cycle pulse: good word dropped because FIFO full

Behaviour:
- Reset (rst_i=1 at posedge): FSM=IDLE, both synchroniser flops=1, bit/baud counters=0, shift reg=0, FIFO pointers/count=0; outputs dout_o=0, empty_o=1, full_o=0, frame_err_o=0, overrun_o=0. Reset mid-frame discards the partial word and all FIFO contents.
- Synchroniser: 2 flops; all logic uses the second stage (rx_s). A third flop (rx_q) holds the previous rx_s for edge detection.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: rx_en_i=1 and falling edge (rx_q=1, rx_s=0) -> START, baud counter=0. A line held low never retriggers, because an edge requires rx_q=1.
- START: at baud counter = BAUD_DIV/2-1, sample rx_s. If 1 -> IDLE (glitch, no output). If 0 -> DATA with counter=0 and bit index=0.
- DATA: sample when counter = BAUD_DIV-1, then clear the counter. Shift the sample into the MSB of the shift reg (right shift), so bit 0 lands in the LSB after DATA_WIDTH samples. After sample index DATA_WIDTH-1 -> STOP.
- STOP: sample at counter = BAUD_DIV-1. If 1 and the FIFO is not full, push the word. If 1 and full, drop the word and pulse overrun_o. If 0, pulse frame_err_o and drop the word. All three cases -> IDLE in the same cycle.
- Latency: the word appears on dout_o with empty_o=0 one cycle after the stop-bit sample edge.
- rx_en_i deassertion mid-frame does not abort; the current frame completes.
- FIFO: push and pop on the same cycle are both honoured, including when full; count is unchanged. Pop on empty is ignored. Push on full is dropped (overrun path). Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH+1).
- frame_err_o and overrun_o are registered and high for exactly one cycle per event.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: every sample point (start, data, stop) uses the 2-of-3 majority of rx_s at counter target-1, target, and target+1. Decision is taken at target+1, and the next bit's counter continues from there so bit spacing stays BAUD_DIV.
- Undefined: single sample of rx_s at the target count.
- Ports are identical in both builds.

Decomposition:
- uart_pkg: rx_state_e enum (IDLE, START, DATA, STOP); function baud_div(clk_freq, baud_rate); shared line constants START_BIT=0 and STOP_BIT=1, also used by uart_tx.
- Sub-module sync_fifo (DATA_WIDTH, FIFO_DEPTH) holds the FIFO storage and flags, shared with uart_tx.
- The FSM, synchroniser and counters live in uart_rx.

Test Plan:
- Loopback: uart_tx.tx_bit_o -> rx_bit_i. Write 'h01, 'h09, 'h00, 'h07 to tx and enable both -> rx FIFO pops 01, 09, 00, 07 in order, no error pulses, empty_o=1 at end.
- False start: drive rx_bit_i low for 100 clocks then high -> FSM back to IDLE, no push, no error pulses.
- Framing: drive frame 'hA5 with stop bit=0 -> frame_err_o high exactly 1 cycle, FIFO stays empty. A following valid 'h3C is received correctly.
- Overrun: send 17 frames 'h00..'h10 without popping -> full_o=1 after the 16th, overrun_o pulses once on the 17th. Popping 16 times yields 'h00..'h0F.
- Control/reset: rx_en_i=0 during a 'h55 frame -> nothing received. rst_i asserted for 1 cycle at data bit 4 of 'hFF -> IDLE, empty_o=1, and the next 'h12 is received.
- Majority (macro defined): a 1-clock low glitch exactly at the mid-sample of bit 0 of 'hFF -> 'hFF received. With the macro undefined, the same stimulus -> 'hFE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divisor helper and
// the line-level start/stop bit values used by both uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Clocks per bit; integer truncation matches the transmitter's divisor.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO shared by the UART blocks.
// A push on a full FIFO is accepted only when a pop frees a slot in the
// same cycle; a pop on an empty FIFO is ignored. The read port shows zero
// while empty so the head is well defined after reset.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  // Pointer and occupancy tracking; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is data only; validity comes from the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_WIDTH data bits LSB first, one stop bit.
// The line is synchronised through two flops, each bit is sampled mid-bit,
// and good words are queued in a receive FIFO read first-word-fall-through.
// Build option UART_RX_MAJORITY_EN: each sample point takes the 2-of-3
// majority around the target count and decides one cycle later; the next
// bit's counter restarts at 1 so the bit spacing stays BAUD_DIV.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int          DATA_WIDTH = 8,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_en_i,
  input  logic                  rx_bit_i,
  input  logic                  rx_ren_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_DIV = BAUD_DIV / 2;
  localparam int          CW       = $clog2(BAUD_DIV + 1);
  localparam int          IW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] START_PT = CW'(HALF_DIV);
  localparam logic [CW-1:0] BIT_PT   = CW'(BAUD_DIV);
  localparam logic [CW-1:0] RELOAD   = CW'(1);
`else
  localparam logic [CW-1:0] START_PT = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] BIT_PT   = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] RELOAD   = '0;
`endif

  logic                  rx_meta;
  logic                  rx_s;
  logic                  rx_q;
  logic                  bit_smp;

  rx_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  push;
  logic                  ferr_d;
  logic                  ovr_d;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rx_bit_i;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rx_qq;

  // Second history flop so three consecutive line samples are available.
  always_ff @(posedge clk_i) begin
    if (rst_i) rx_qq <= 1'b1;
    else       rx_qq <= rx_q;
  end

  assign bit_smp = (rx_s & rx_q) | (rx_s & rx_qq) | (rx_q & rx_qq);
`else
  assign bit_smp = rx_s;
`endif

  // Frame sequencing: next state, counters, shift register and events.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_en_i && rx_q && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == START_PT) begin
          if (bit_smp != START_BIT) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = DATA;
            cnt_d   = RELOAD;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_PT) begin
          shift_d = {bit_smp, shift_q[DATA_WIDTH-1:1]};
          cnt_d   = RELOAD;
          if (idx_q == IW'(DATA_WIDTH - 1)) state_d = STOP;
          else                              idx_d   = idx_q + IW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_PT) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (bit_smp != STOP_BIT) ferr_d = 1'b1;
          else if (full_o)         ovr_d  = 1'b1;
          else                     push   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and shift register update; reset abandons any partial word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Error events are registered so each one is a clean single-cycle pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= ferr_d;
      overrun_o   <= ovr_d;
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (push),
    .wr_data (shift_q),
    .rd_en   (rx_ren_i),
    .rd_data (dout_o),
    .empty   (empty_o),
    .full    (full_o)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial line driver feeds frames, a frame
// level model predicts received words and error events, and a monitor pops
// the FIFO and compares each word against the expected queue.
module tb_uart_rx;

  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int DW       = 8;
  localparam int DEPTH    = 16;
  localparam int BD       = CLK_FREQ / BAUD;
  localparam int HALF     = BD / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Push edge counted from the edge that launches the start bit: two
  // synchroniser flops plus edge detect, half a bit, nine full bits.
  localparam int LAT = HALF + 3 + 9 * BD + MAJ;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          rx_en_i;
  logic          rx_bit_i;
  logic          rx_ren_i;
  logic [DW-1:0] dout_o;
  logic          empty_o;
  logic          full_o;
  logic          frame_err_o;
  logic          overrun_o;

  always #5 clk_i = ~clk_i;

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_en_i     (rx_en_i),
    .rx_bit_i    (rx_bit_i),
    .rx_ren_i    (rx_ren_i),
    .dout_o      (dout_o),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  int            tests    = 0;
  int            fails    = 0;
  int            exp_ferr = 0;
  int            exp_ovr  = 0;
  int            got_ferr = 0;
  int            got_ovr  = 0;
  bit            pop_en   = 1'b0;
  logic          ferr_prev = 1'b0;
  logic          ovr_prev  = 1'b0;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference: what a correct receiver does with one frame.
  task automatic model_frame(input logic [DW-1:0] d, input logic stop, input bit enabled);
    if (enabled) begin
      if (stop == 1'b0)                          exp_ferr++;
      else if (!pop_en && exp_q.size() == DEPTH) exp_ovr++;
      else                                       exp_q.push_back(d);
    end
  endtask

  // Drive one frame, one line value per clock; optional one-clock glitch
  // and optional enable drop at a given clock of the frame.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop,
                            input int glitch_n, input int en_drop_n, input int gap);
    logic [DW+1:0] bits;
    bits = {stop, d, 1'b0};
    for (int n = 0; n < (DW + 2) * BD; n++) begin
      @(posedge clk_i); #1;
      rx_bit_i = bits[n / BD] ^ (n == glitch_n);
      if (n == en_drop_n) rx_en_i = 1'b0;
    end
    @(posedge clk_i); #1;
    rx_bit_i = 1'b1;
    repeat (gap) @(posedge clk_i);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk_i);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_events(input string tag);
    check({tag, "_ferr_cnt"}, got_ferr, exp_ferr);
    check({tag, "_ovr_cnt"}, got_ovr, exp_ovr);
  endtask

  // Monitor: counts error pulses, checks their width, pops and scores words.
  initial begin
    rx_ren_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (frame_err_o) begin
        got_ferr++;
        check("ferr_pulse_width", ferr_prev, 0);
      end
      if (overrun_o) begin
        got_ovr++;
        check("ovr_pulse_width", ovr_prev, 0);
      end
      ferr_prev = frame_err_o;
      ovr_prev  = overrun_o;
      if (pop_en && !empty_o && !rst_i) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h, no word expected", dout_o);
        end else begin
          check("rx_word", dout_o, exp_q.pop_front());
        end
        rx_ren_i = 1'b1;
      end else begin
        rx_ren_i = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not finish, %0d tests so far", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d;
    int            kind;
    int            gap;
    logic [DW-1:0] words [4];
    words = '{8'h01, 8'h09, 8'h00, 8'h07};

    rst_i    = 1'b1;
    rx_en_i  = 1'b0;
    rx_bit_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_dout", dout_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_ovr", overrun_o, 0);

    // Basic words in order.
    pop_en  = 1'b1;
    rx_en_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      model_frame(words[i], 1'b1, 1'b1);
      send_frame(words[i], 1'b1, -1, -1, 8);
    end
    wait_drain("loop_drain");
    check_events("loop");
    @(negedge clk_i);
    check("loop_empty", empty_o, 1);

    // Exact arrival cycle of a word.
    model_frame(8'hC3, 1'b1, 1'b1);
    fork
      send_frame(8'hC3, 1'b1, -1, -1, 8);
      begin
        repeat (LAT) @(posedge clk_i);
        @(negedge clk_i);
        check("lat_before", empty_o, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        check("lat_after", empty_o, 0);
        check("lat_word", dout_o, 8'hC3);
      end
    join
    wait_drain("lat_drain");

    // False start shorter than half a bit.
    for (int n = 0; n < 12; n++) begin
      @(posedge clk_i); #1 rx_bit_i = 1'b0;
    end
    @(posedge clk_i); #1 rx_bit_i = 1'b1;
    repeat (2 * BD) @(posedge clk_i);
    @(negedge clk_i);
    check("false_start_empty", empty_o, 1);
    check_events("false_start");

    // Bad stop bit, then a good frame.
    model_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, -1, -1, 8);
    @(negedge clk_i);
    check("framing_empty", empty_o, 1);
    check_events("framing");
    model_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, -1, -1, 8);
    wait_drain("framing_drain");

    // Receiver disabled for a whole frame.
    rx_en_i = 1'b0;
    model_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, -1, -1, 8);
    rx_en_i = 1'b1;
    @(negedge clk_i);
    check("disabled_empty", empty_o, 1);
    check_events("disabled");

    // Reset mid-frame flushes the FIFO and the partial word.
    pop_en = 1'b0;
    model_frame(8'h77, 1'b1, 1'b1);
    send_frame(8'h77, 1'b1, -1, -1, 8);
    @(negedge clk_i);
    check("pre_reset_full_word", empty_o, 0);
    fork
      send_frame(8'hFF, 1'b1, -1, -1, 8);
      begin
        repeat (5 * BD + HALF) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        check("post_reset_empty", empty_o, 1);
      end
    join
    @(negedge clk_i);
    check("after_reset_frame_empty", empty_o, 1);
    pop_en = 1'b1;
    model_frame(8'h12, 1'b1, 1'b1);
    send_frame(8'h12, 1'b1, -1, -1, 8);
    wait_drain("reset_drain");
    check_events("reset");

    // One-clock glitch at the centre of data bit 0.
    exp_q.push_back(MAJ ? 8'hFF : 8'hFE);
    send_frame(8'hFF, 1'b1, BD + HALF, -1, 8);
    wait_drain("glitch_drain");

    // Fill without popping, then overflow by one.
    pop_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      model_frame(DW'(i), 1'b1, 1'b1);
      send_frame(DW'(i), 1'b1, -1, -1, 4);
    end
    @(negedge clk_i);
    check("ovr_full_at_16", full_o, 1);
    check_events("ovr_16");
    model_frame(8'h10, 1'b1, 1'b1);
    send_frame(8'h10, 1'b1, -1, -1, 8);
    @(negedge clk_i);
    check("ovr_full_at_17", full_o, 1);
    check_events("ovr_17");
    pop_en = 1'b1;
    wait_drain("ovr_drain");
    @(negedge clk_i);
    check("ovr_empty_end", empty_o, 1);

    // Randomised mix of good, bad-stop, disabled and enable-drop frames.
    for (int i = 0; i < 30; i++) begin
      d    = DW'($urandom);
      kind = $urandom_range(0, 9);
      gap  = $urandom_range(4, 40);
      if (kind <= 6) begin
        model_frame(d, 1'b1, 1'b1);
        send_frame(d, 1'b1, -1, -1, gap);
      end else if (kind == 7) begin
        model_frame(d, 1'b0, 1'b1);
        send_frame(d, 1'b0, -1, -1, gap);
      end else if (kind == 8) begin
        rx_en_i = 1'b0;
        model_frame(d, 1'b1, 1'b0);
        send_frame(d, 1'b1, -1, -1, gap);
        rx_en_i = 1'b1;
      end else begin
        model_frame(d, 1'b1, 1'b1);
        send_frame(d, 1'b1, -1, $urandom_range(BD, 9 * BD), gap);
        rx_en_i = 1'b1;
      end
    end
    wait_drain("rand_drain");
    repeat (4) @(posedge clk_i);
    check_events("rand");
    @(negedge clk_i);
    check("final_empty", empty_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
